// File: rtl/biu_pkg.sv
// Shared types and constants for the 8088/8086-class bus interface unit.
//   bus_state_t : bus cycle states TI, T1, T2, T3, TW, T4
//   cyc_owner_t : which requester owns the running bus cycle
//   RESET_VEC_DEFAULT : prefetch pointer after reset
//   q_wrap      : folds a queue index back into 0..depth-1
package biu_pkg;

    typedef enum logic [2:0] {TI, T1, T2, T3, TW, T4} bus_state_t;

    typedef enum logic [1:0] {CYC_NONE, CYC_CPU, CYC_PREF} cyc_owner_t;

    localparam logic [19:0] RESET_VEC_DEFAULT = 20'hFFFF0;

    // Index never exceeds 2*depth-2, so one conditional subtract is enough.
    function automatic logic [2:0] q_wrap(input logic [3:0] idx, input logic [3:0] depth);
        return (idx >= depth) ? 3'(idx - depth) : idx[2:0];
    endfunction

endpackage

// File: rtl/bus_interface_unit_queue.sv
// Instruction prefetch queue: byte FIFO of DEPTH entries (2..8).
//   clk, rst     : clock, asynchronous active-high reset
//   i_flush      : empty the queue (wins over push and pop in the same clock)
//   i_push       : write i_push_n bytes (1..BUS_BYTES) from i_push_data, byte 0 first
//   i_pop        : consume the head byte; ignored while empty
//   o_valid      : queue not empty
//   o_head       : head byte
//   o_free       : number of free entries
module prefetch_queue
    import biu_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BUS_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [1:0]             i_push_n,
    input  logic [8*BUS_BYTES-1:0] i_push_data,
    input  logic                   i_pop,
    output logic                   o_valid,
    output logic [7:0]             o_head,
    output logic [3:0]             o_free
);

    localparam logic [3:0] DEPTH4 = 4'(DEPTH);

    logic [7:0] r_mem [8];
    logic [2:0] r_rd;
    logic [3:0] r_cnt;
    logic       w_pop;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_valid = (r_cnt != '0);
    assign o_head  = r_mem[r_rd];
    assign o_free  = DEPTH4 - r_cnt;

    // Tail is computed from the pre-pop count, so a same-clock pop never moves it.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            for (int unsigned k = 0; k < BUS_BYTES; k++) begin
                if (k < 32'(i_push_n))
                    r_mem[q_wrap({1'b0, r_rd} + r_cnt + 4'(k), DEPTH4)] <= i_push_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_pop)
                r_rd <= q_wrap({1'b0, r_rd} + 4'd1, DEPTH4);
            r_cnt <= r_cnt + (i_push ? {2'b00, i_push_n} : 4'd0) - {3'b000, w_pop};
        end
    end

endmodule

// File: rtl/bus_interface_unit.sv
// 8088/8086-class bus interface unit.
// Runs T1-T2-T3-[TW]-T4 cycles on a multiplexed bus, splits core word accesses
// into byte-lane cycles and fills a prefetch queue when the core is idle.
//   clk, rst                : clock, asynchronous active-high reset
//   cpu_req/we/word/io/adr  : core data access request (held until cpu_ack)
//   cpu_dat_o / cpu_dat_i   : core write data / read data (valid with cpu_ack)
//   cpu_ack                 : one-cycle completion pulse in T4 of the last cycle
//   q_flush/q_flush_adr     : discard queue, reload prefetch pointer
//   q_pop/q_valid/q_byte    : queue consume port
//   ready                   : external ready, low inserts TW
//   a, ad_o, ad_i, ad_oe    : latched address and data lanes
//   ale, rd_n, wr_n, den_n, dtr, iom : bus strobes
module bus_interface_unit
    import biu_pkg::*;
#(
    parameter int unsigned BUS_BYTES   = 1,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [19:0] RESET_VEC   = RESET_VEC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic                   cpu_word,
    input  logic                   cpu_io,
    input  logic [19:0]            cpu_adr,
    input  logic [15:0]            cpu_dat_o,
    output logic                   cpu_ack,
    output logic [15:0]            cpu_dat_i,
    input  logic                   q_flush,
    input  logic [19:0]            q_flush_adr,
    input  logic                   q_pop,
    output logic                   q_valid,
    output logic [7:0]             q_byte,
    input  logic                   ready,
    output logic [19:0]            a,
    output logic [8*BUS_BYTES-1:0] ad_o,
    input  logic [8*BUS_BYTES-1:0] ad_i,
    output logic                   ad_oe,
    output logic                   ale,
    output logic                   rd_n,
    output logic                   wr_n,
    output logic                   den_n,
    output logic                   dtr,
    output logic                   iom
);

    localparam int unsigned DW = 8 * BUS_BYTES;

    bus_state_t  r_state, w_next;
    cyc_owner_t  r_owner;
    logic [19:0] r_a, r_ptr;
    logic        r_we, r_io, r_split, r_hi, r_full, r_pf_two, r_drop;
    logic [15:0] r_cpu_wd, r_wd, r_rdata;
    logic [15:0] w_ad16, w_push16;
    logic [DW-1:0] w_push_data;
    logic [7:0]  w_rbyte;
    logic [3:0]  w_free;
    logic [1:0]  w_push_n;
    logic        w_ack, w_cpu_go, w_pf_go, w_start, w_cap, w_active, w_push, w_full;

    assign w_ad16   = 16'(ad_i);
    assign w_ack    = (r_state == T4) && (r_owner == CYC_CPU) && !r_split;
    // The request is still high during its own ack clock; it must not restart.
    assign w_cpu_go = r_split || (cpu_req && !w_ack);
    assign w_pf_go  = !q_flush && (w_free >= 4'(BUS_BYTES));
    assign w_start  = (w_next == T1);
    assign w_cap    = ((r_state == T3) || (r_state == TW)) && ready;
    assign w_active = (r_state == T1) || (r_state == T2) || (r_state == T3) || (r_state == TW);
    assign w_full   = cpu_word && (BUS_BYTES == 2) && !cpu_adr[0];

    // Odd address on a 16-bit bus lives on the upper lane.
    assign w_rbyte     = ((BUS_BYTES == 2) && r_a[0]) ? w_ad16[15:8] : w_ad16[7:0];
    assign w_push      = w_cap && (r_owner == CYC_PREF) && !r_drop && !q_flush;
    assign w_push_n    = r_pf_two ? 2'd2 : 2'd1;
    assign w_push16    = r_pf_two ? w_ad16 : {8'h00, w_rbyte};
    assign w_push_data = DW'(w_push16);

    assign a         = r_a;
    assign ad_o      = DW'(r_wd);
    assign cpu_ack   = w_ack;
    assign cpu_dat_i = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= TI;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TI:      if (w_cpu_go || w_pf_go) w_next = T1;
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3, TW:  w_next = ready ? T4 : TW;
            T4:      w_next = (w_cpu_go || w_pf_go) ? T1 : TI;
            default: w_next = TI;
        endcase
    end

    always_comb begin
        ale   = 1'b0;
        rd_n  = 1'b1;
        wr_n  = 1'b1;
        den_n = 1'b1;
        dtr   = 1'b1;
        iom   = 1'b0;
        ad_oe = 1'b0;
        case (r_state)
            T1, T4: begin
                ale   = (r_state == T1);
                iom   = r_io;
                ad_oe = r_we;
            end
            T2, T3, TW: begin
                rd_n  = r_we;
                wr_n  = !r_we;
                den_n = 1'b0;
                dtr   = r_we;
                iom   = r_io;
                ad_oe = r_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner  <= CYC_NONE;
            r_a      <= '0;
            r_ptr    <= RESET_VEC;
            r_we     <= 1'b0;
            r_io     <= 1'b0;
            r_split  <= 1'b0;
            r_hi     <= 1'b0;
            r_full   <= 1'b0;
            r_pf_two <= 1'b0;
            r_drop   <= 1'b0;
            r_cpu_wd <= '0;
            r_wd     <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_start) begin
                if (w_cpu_go) begin
                    r_owner <= CYC_CPU;
                    if (r_split) begin
                        r_a     <= r_a + 20'd1;
                        r_hi    <= 1'b1;
                        r_split <= 1'b0;
                        r_full  <= 1'b0;
                        r_wd    <= {2{r_cpu_wd[15:8]}};
                    end else begin
                        r_a      <= cpu_adr;
                        r_we     <= cpu_we;
                        r_io     <= cpu_io;
                        r_cpu_wd <= cpu_dat_o;
                        r_hi     <= 1'b0;
                        r_full   <= w_full;
                        r_split  <= cpu_word && !w_full;
                        r_wd     <= w_full ? cpu_dat_o : {2{cpu_dat_o[7:0]}};
                    end
                end else begin
                    r_owner  <= CYC_PREF;
                    r_a      <= r_ptr;
                    r_we     <= 1'b0;
                    r_io     <= 1'b0;
                    r_pf_two <= (BUS_BYTES == 2) && !r_ptr[0];
                end
            end else if (w_next == TI) begin
                r_owner <= CYC_NONE;
            end

            // A flush during a running prefetch lets it finish but discards its data.
            if (w_start)
                r_drop <= 1'b0;
            else if (q_flush && (r_owner == CYC_PREF) && w_active)
                r_drop <= 1'b1;

            if (w_cap && (r_owner == CYC_CPU) && !r_we) begin
                if (r_full)    r_rdata       <= w_ad16;
                else if (r_hi) r_rdata[15:8] <= w_rbyte;
                else           r_rdata       <= {8'h00, w_rbyte};
            end

            if (q_flush)     r_ptr <= q_flush_adr;
            else if (w_push) r_ptr <= r_ptr + 20'(w_push_n);
        end
    end

    prefetch_queue #(
        .DEPTH     (QUEUE_DEPTH),
        .BUS_BYTES (BUS_BYTES)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (q_flush),
        .i_push      (w_push),
        .i_push_n    (w_push_n),
        .i_push_data (w_push_data),
        .i_pop       (q_pop),
        .o_valid     (q_valid),
        .o_head      (q_byte),
        .o_free      (w_free)
    );

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit: one 8088-style instance (u1) and
// one 8086-style instance (u2). Memory model: byte at address x = x[7:0]^A5.
module tb_bus_interface_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic logic [7:0] bmem(input logic [19:0] x);
        return x[7:0] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // u1 signals (BUS_BYTES=1, depth 4)
    logic        rst1 = 1'b1, req1 = 1'b0, we1 = 1'b0, word1 = 1'b0, io1 = 1'b0;
    logic [19:0] adr1 = '0, fadr1 = '0, a1;
    logic [15:0] dat1 = '0, dati1;
    logic        ack1, flush1 = 1'b0, pop1 = 1'b0, qv1, ready1 = 1'b1;
    logic [7:0]  qb1, ad_o1, ad_i1;
    logic        oe1, ale1, rd_n1, wr_n1, den_n1, dtr1, iom1;

    // u2 signals (BUS_BYTES=2, depth 6)
    logic        rst2 = 1'b1, req2 = 1'b0, word2 = 1'b0;
    logic [19:0] adr2 = '0, fadr2 = '0, a2;
    logic [15:0] dati2, ad_o2, ad_i2;
    logic        ack2, flush2 = 1'b0, qv2, ready2 = 1'b1;
    logic [7:0]  qb2;
    logic        oe2, ale2, rd_n2, wr_n2, den_n2, dtr2, iom2;

    assign ad_i1 = bmem(a1);
    assign ad_i2 = {bmem({a2[19:1], 1'b1}), bmem({a2[19:1], 1'b0})};

    bus_interface_unit #(.BUS_BYTES(1), .QUEUE_DEPTH(4), .RESET_VEC(20'hFFFF0)) u1 (
        .clk(clk), .rst(rst1), .cpu_req(req1), .cpu_we(we1), .cpu_word(word1), .cpu_io(io1),
        .cpu_adr(adr1), .cpu_dat_o(dat1), .cpu_ack(ack1), .cpu_dat_i(dati1),
        .q_flush(flush1), .q_flush_adr(fadr1), .q_pop(pop1), .q_valid(qv1), .q_byte(qb1),
        .ready(ready1), .a(a1), .ad_o(ad_o1), .ad_i(ad_i1), .ad_oe(oe1), .ale(ale1),
        .rd_n(rd_n1), .wr_n(wr_n1), .den_n(den_n1), .dtr(dtr1), .iom(iom1)
    );

    bus_interface_unit #(.BUS_BYTES(2), .QUEUE_DEPTH(6), .RESET_VEC(20'hFFFF0)) u2 (
        .clk(clk), .rst(rst2), .cpu_req(req2), .cpu_we(1'b0), .cpu_word(word2), .cpu_io(1'b0),
        .cpu_adr(adr2), .cpu_dat_o(16'h0000), .cpu_ack(ack2), .cpu_dat_i(dati2),
        .q_flush(flush2), .q_flush_adr(fadr2), .q_pop(1'b0), .q_valid(qv2), .q_byte(qb2),
        .ready(ready2), .a(a2), .ad_o(ad_o2), .ad_i(ad_i2), .ad_oe(oe2), .ale(ale2),
        .rd_n(rd_n2), .wr_n(wr_n2), .den_n(den_n2), .dtr(dtr2), .iom(iom2)
    );

    int unsigned n_ale, n_lo, ack_at, ale_at, n_ack;
    logic [19:0] adrs [4];
    logic [7:0]  dats [4];

    initial begin
        // ---- 1: reset values, then idle prefetch fill ----
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({ale1, rd_n1, wr_n1, den_n1, dtr1, iom1, oe1, ack1, qv1}), 32'b011110000);
        chk("rst_a", 32'(a1), 32'h0);
        chk("rst_dat_i", 32'(dati1), 32'h0);
        rst1 = 1'b0;
        rst2 = 1'b0;
        n_ale = 0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ale1) begin
                if (n_ale < 4) adrs[n_ale] = a1;
                n_ale++;
            end
        end
        chk("pf_count", n_ale, 4);
        chk("pf_a0", 32'(adrs[0]), 32'hFFFF0);
        chk("pf_a3", 32'(adrs[3]), 32'hFFFF3);
        chk("pf_idle", 32'({rd_n1, den_n1, qv1}), 32'b111);
        chk("pf_qbyte", 32'(qb1), 32'h55);
        chk("pf2_qbyte", 32'({qv2, qb2}), 32'h155);

        // ---- 2: byte read 0x00400 with two wait states ----
        ready1 = 1'b0; adr1 = 20'h00400; we1 = 1'b0; word1 = 1'b0; io1 = 1'b0; req1 = 1'b1;
        n_lo = 0; ack_at = 0; ale_at = 0;
        for (int unsigned i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ale1) begin
                ale_at = i;
                chk("rd_addr", 32'(a1), 32'h00400);
            end
            if (!rd_n1) n_lo++;
            if (i == 2) chk("rd_dtr_den", 32'({dtr1, den_n1}), 32'b00);
            if (i == 5) ready1 = 1'b1;
            if (ack1 && ack_at == 0) begin
                ack_at = i;
                chk("rd_data", 32'(dati1), 32'h00A5);
                req1 = 1'b0;
            end
        end
        req1 = 1'b0;
        chk("rd_ale_at", ale_at, 1);
        chk("rd_rdn_clocks", n_lo, 4);
        chk("rd_ack_at", ack_at, 6);

        // ---- 3: word write 0xBEEF at 0xFFFFF, I/O space, wraps ----
        adr1 = 20'hFFFFF; we1 = 1'b1; word1 = 1'b1; io1 = 1'b1; dat1 = 16'hBEEF; req1 = 1'b1;
        n_ale = 0; n_lo = 0; n_ack = 0; ack_at = 0;
        for (int unsigned i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (ale1) begin
                if (n_ale < 4) begin adrs[n_ale] = a1; dats[n_ale] = ad_o1; end
                n_ale++;
            end
            if (!wr_n1) n_lo++;
            if (i == 1) chk("wr_oe_t1", 32'(oe1), 32'h1);
            if (i == 2) chk("wr_iom_dtr", 32'({iom1, dtr1, rd_n1}), 32'b111);
            if (ack1) begin
                n_ack++;
                if (ack_at == 0) ack_at = i;
                req1 = 1'b0;
            end
        end
        req1 = 1'b0; we1 = 1'b0; word1 = 1'b0; io1 = 1'b0;
        chk("wr_cycles", n_ale, 2);
        chk("wr_a0_d0", 32'({adrs[0], dats[0]}), 32'hFFFFFEF);
        chk("wr_a1_d1", 32'({adrs[1], dats[1]}), 32'h00000BE);
        chk("wr_wrn_clocks", n_lo, 4);
        chk("wr_acks", n_ack, 1);
        chk("wr_ack_at", ack_at, 8);

        // ---- 4: BUS_BYTES=2 word reads, aligned and odd ----
        adr2 = 20'h00100; word2 = 1'b1; req2 = 1'b1;
        n_ale = 0; ack_at = 0;
        for (int unsigned i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ale2) n_ale++;
            if (ack2 && ack_at == 0) begin
                ack_at = i;
                chk("w2_even_data", 32'(dati2), 32'hA4A5);
                req2 = 1'b0;
            end
        end
        req2 = 1'b0;
        chk("w2_even_cycles", n_ale, 1);
        chk("w2_even_ack_at", ack_at, 4);
        adr2 = 20'h00101; req2 = 1'b1;
        n_ale = 0; ack_at = 0;
        for (int unsigned i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ale2) begin
                if (n_ale < 4) adrs[n_ale] = a2;
                n_ale++;
            end
            if (ack2 && ack_at == 0) begin
                ack_at = i;
                chk("w2_odd_data", 32'(dati2), 32'hA7A4);
                req2 = 1'b0;
            end
        end
        req2 = 1'b0;
        chk("w2_odd_cycles", n_ale, 2);
        chk("w2_odd_a1", 32'(adrs[1]), 32'h00102);
        chk("w2_odd_ack_at", ack_at, 8);

        // BUS_BYTES=2 flush to an odd address: one realigning byte first
        fadr2 = 20'h00011; flush2 = 1'b1;
        @(negedge clk);
        flush2 = 1'b0;
        n_ale = 0;
        for (int unsigned i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ale2) begin
                if (n_ale < 4) adrs[n_ale] = a2;
                n_ale++;
            end
        end
        chk("al_cycles", n_ale, 3);
        chk("al_a0", 32'(adrs[0]), 32'h00011);
        chk("al_a1", 32'(adrs[1]), 32'h00012);
        chk("al_a2", 32'(adrs[2]), 32'h00014);
        chk("al_qbyte", 32'(qb2), 32'hB4);

        // ---- 5: pop, then flush to 0x01234 during a prefetch T3 ----
        pop1 = 1'b1;
        @(negedge clk);
        pop1 = 1'b0;
        chk("pop_qbyte", 32'(qb1), 32'h54);
        ale_at = 0;
        for (int unsigned i = 1; i <= 10; i++) begin
            if (ale_at == 0) begin
                @(negedge clk);
                if (ale1) begin
                    ale_at = i;
                    chk("fl_pf_addr", 32'(a1), 32'hFFFF4);
                end
            end
        end
        chk("fl_pf_seen", 32'(ale_at != 0), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("fl_in_t3", 32'({den_n1, rd_n1}), 32'b00);
        fadr1 = 20'h01234; flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        chk("fl_empty", 32'(qv1), 32'h0);
        @(negedge clk);
        chk("fl_next_pf", 32'({ale1, a1}), 32'h101234);
        repeat (20) @(negedge clk);
        chk("fl_refill", 32'({qv1, qb1}), 32'h191);

        // ---- 6: reset during TW of a write ----
        ready1 = 1'b0; adr1 = 20'h00010; we1 = 1'b1; word1 = 1'b0; dat1 = 16'h005A; req1 = 1'b1;
        for (int unsigned i = 1; i <= 4; i++) @(negedge clk);
        chk("rs_in_tw", 32'({wr_n1, oe1}), 32'b01);
        rst1 = 1'b1;
        #1;
        chk("rs_abort", 32'({wr_n1, oe1, ack1}), 32'b100);
        req1 = 1'b0; we1 = 1'b0; ready1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk("rs_ptr", 32'({ale1, a1}), 32'h1FFFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
